// File: rtl/memory_access_stage.sv
// MEM pipeline stage: issues aligned loads/stores to the data cache, formats load and
// store data, and registers the write-back stage inputs. Stalls upstream while busy.
module memory_access_stage #(
  parameter int ADDRESS_WIDTH    = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int REG_ADD_WIDTH    = 5,
  parameter int D_CACHE_LW_WIDTH = 3,
  parameter int D_CACHE_SW_WIDTH = 2
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [REG_ADD_WIDTH-1:0]      RD_ADDRESS_IN,
  input  logic [ADDRESS_WIDTH-1:0]      ALU_IN,
  input  logic [D_CACHE_LW_WIDTH-1:0]   DATA_CACHE_LOAD_IN,
  input  logic [D_CACHE_SW_WIDTH-1:0]   DATA_CACHE_STORE_IN,
  input  logic [DATA_WIDTH-1:0]         DATA_CACHE_STORE_DATA_IN,
  input  logic                          WRITE_BACK_MUX_SELECT_IN,
  input  logic                          RD_WRITE_ENABLE_IN,
  output logic                          STALL_PIPELINE,
  output logic                          DCACHE_REQ_VALID,
  input  logic                          DCACHE_REQ_READY,
  output logic [ADDRESS_WIDTH-1:0]      DCACHE_ADDR,
  output logic                          DCACHE_WE,
  output logic [DATA_WIDTH/8-1:0]       DCACHE_BYTE_EN,
  output logic [DATA_WIDTH-1:0]         DCACHE_WDATA,
  input  logic                          DCACHE_RVALID,
  input  logic [DATA_WIDTH-1:0]         DCACHE_RDATA,
  output logic [REG_ADD_WIDTH-1:0]      RD_ADDRESS_OUT,
  output logic [DATA_WIDTH-1:0]         WB_DATA_OUT,
  output logic                          RD_WRITE_ENABLE_OUT,
  output logic                          MISALIGN_FAULT,
  output logic [1:0]                    FSM_STATE_DBG
);
  // Handshake: DCACHE_REQ_VALID rises with ADDR/WE/BYTE_EN/WDATA, all held stable until a
  // rising edge sees VALID&READY; a load then waits for one single-cycle DCACHE_RVALID.
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2} state_t;

  localparam logic [D_CACHE_LW_WIDTH-1:0] LD_LW  = D_CACHE_LW_WIDTH'(1);
  localparam logic [D_CACHE_LW_WIDTH-1:0] LD_LH  = D_CACHE_LW_WIDTH'(2);
  localparam logic [D_CACHE_LW_WIDTH-1:0] LD_LHU = D_CACHE_LW_WIDTH'(3);
  localparam logic [D_CACHE_LW_WIDTH-1:0] LD_LB  = D_CACHE_LW_WIDTH'(4);
  localparam logic [D_CACHE_LW_WIDTH-1:0] LD_LBU = D_CACHE_LW_WIDTH'(5);
  localparam logic [D_CACHE_SW_WIDTH-1:0] SW_NONE = D_CACHE_SW_WIDTH'(0);
  localparam logic [D_CACHE_SW_WIDTH-1:0] SW_SW   = D_CACHE_SW_WIDTH'(1);
  localparam logic [D_CACHE_SW_WIDTH-1:0] SW_SH   = D_CACHE_SW_WIDTH'(2);

  state_t                        state;
  logic [D_CACHE_LW_WIDTH-1:0]   lat_load;
  logic                          lat_is_store;
  logic [1:0]                    lat_offset;
  logic [REG_ADD_WIDTH-1:0]      lat_rd;
  logic                          lat_we;
  logic                          lat_wb_sel;
  logic [DATA_WIDTH-1:0]         lat_alu;

  logic                          load_valid;
  logic                          store_valid;
  logic                          misalign;
  logic                          issue;
  logic [DATA_WIDTH/8-1:0]       st_be;
  logic [DATA_WIDTH-1:0]         st_wdata;
  logic [7:0]                    ld_byte;
  logic [15:0]                   ld_half;
  logic [DATA_WIDTH-1:0]         ld_fmt;

  // Decode: a valid load code wins over any store code on the same op.
  always_comb begin
    load_valid = 1'b0;
    case (DATA_CACHE_LOAD_IN)
      LD_LW, LD_LH, LD_LHU, LD_LB, LD_LBU: load_valid = 1'b1;
      default: load_valid = 1'b0;
    endcase
    store_valid = !load_valid && (DATA_CACHE_STORE_IN != SW_NONE);
    misalign = 1'b0;
    if (load_valid) begin
      if (DATA_CACHE_LOAD_IN == LD_LW) misalign = (ALU_IN[1:0] != 2'b00);
      else if (DATA_CACHE_LOAD_IN == LD_LH || DATA_CACHE_LOAD_IN == LD_LHU) misalign = ALU_IN[0];
    end else if (store_valid) begin
      if (DATA_CACHE_STORE_IN == SW_SW) misalign = (ALU_IN[1:0] != 2'b00);
      else if (DATA_CACHE_STORE_IN == SW_SH) misalign = ALU_IN[0];
    end
    issue = (load_valid || store_valid) && !misalign;
  end

  always_comb begin
    st_be    = '0;
    st_wdata = '0;
    case (DATA_CACHE_STORE_IN)
      SW_SW: begin
        st_be    = '1;
        st_wdata = DATA_CACHE_STORE_DATA_IN;
      end
      SW_SH: begin
        st_be    = 4'b0011 << {ALU_IN[1], 1'b0};
        st_wdata = {2{DATA_CACHE_STORE_DATA_IN[15:0]}};
      end
      default: begin
        st_be    = 4'b0001 << ALU_IN[1:0];
        st_wdata = {4{DATA_CACHE_STORE_DATA_IN[7:0]}};
      end
    endcase
  end

  always_comb begin
    case (lat_offset)
      2'd0:    ld_byte = DCACHE_RDATA[7:0];
      2'd1:    ld_byte = DCACHE_RDATA[15:8];
      2'd2:    ld_byte = DCACHE_RDATA[23:16];
      default: ld_byte = DCACHE_RDATA[31:24];
    endcase
    ld_half = lat_offset[1] ? DCACHE_RDATA[31:16] : DCACHE_RDATA[15:0];
    case (lat_load)
      LD_LH:   ld_fmt = {{16{ld_half[15]}}, ld_half};
      LD_LHU:  ld_fmt = {16'h0000, ld_half};
      LD_LB:   ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU:  ld_fmt = {24'h000000, ld_byte};
      default: ld_fmt = DCACHE_RDATA;
    endcase
  end

  // Low in the completion cycle so EX advances on the same edge the WB regs update.
  always_comb begin
    case (state)
      ST_IDLE: STALL_PIPELINE = issue;
      ST_REQ:  STALL_PIPELINE = !(DCACHE_REQ_READY && lat_is_store);
      ST_WAIT: STALL_PIPELINE = !DCACHE_RVALID;
      default: STALL_PIPELINE = 1'b0;
    endcase
  end

  assign FSM_STATE_DBG = state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state               <= ST_IDLE;
      lat_load            <= '0;
      lat_is_store        <= 1'b0;
      lat_offset          <= '0;
      lat_rd              <= '0;
      lat_we              <= 1'b0;
      lat_wb_sel          <= 1'b0;
      lat_alu             <= '0;
      DCACHE_REQ_VALID    <= 1'b0;
      DCACHE_ADDR         <= '0;
      DCACHE_WE           <= 1'b0;
      DCACHE_BYTE_EN      <= '0;
      DCACHE_WDATA        <= '0;
      RD_ADDRESS_OUT      <= '0;
      WB_DATA_OUT         <= '0;
      RD_WRITE_ENABLE_OUT <= 1'b0;
      MISALIGN_FAULT      <= 1'b0;
    end else begin
      MISALIGN_FAULT <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            state               <= ST_REQ;
            lat_load            <= load_valid ? DATA_CACHE_LOAD_IN : '0;
            lat_is_store        <= store_valid;
            lat_offset          <= ALU_IN[1:0];
            lat_rd              <= RD_ADDRESS_IN;
            lat_we              <= RD_WRITE_ENABLE_IN;
            lat_wb_sel          <= WRITE_BACK_MUX_SELECT_IN;
            lat_alu             <= ALU_IN;
            DCACHE_REQ_VALID    <= 1'b1;
            DCACHE_ADDR         <= {ALU_IN[ADDRESS_WIDTH-1:2], 2'b00};
            DCACHE_WE           <= store_valid;
            DCACHE_BYTE_EN      <= store_valid ? st_be : '0;
            DCACHE_WDATA        <= store_valid ? st_wdata : '0;
            RD_WRITE_ENABLE_OUT <= 1'b0;
          end else begin
            RD_ADDRESS_OUT      <= RD_ADDRESS_IN;
            WB_DATA_OUT         <= ALU_IN;
            RD_WRITE_ENABLE_OUT <= RD_WRITE_ENABLE_IN && !misalign;
            MISALIGN_FAULT      <= misalign;
          end
        end
        ST_REQ: begin
          RD_WRITE_ENABLE_OUT <= 1'b0;
          if (DCACHE_REQ_READY) begin
            DCACHE_REQ_VALID <= 1'b0;
            state            <= lat_is_store ? ST_IDLE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (DCACHE_RVALID) begin
            state               <= ST_IDLE;
            RD_ADDRESS_OUT      <= lat_rd;
            WB_DATA_OUT         <= lat_wb_sel ? ld_fmt : lat_alu;
            RD_WRITE_ENABLE_OUT <= lat_we;
          end else begin
            RD_WRITE_ENABLE_OUT <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_access_stage.sv
// Directed + short random bench for memory_access_stage: cache responder model,
// request and write-back scoreboards, latency and fault checks.
module tb_memory_access_stage;
  localparam int WB_W  = 37;
  localparam int REQ_W = 69;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [4:0]  RD_ADDRESS_IN;
  logic [31:0] ALU_IN;
  logic [2:0]  DATA_CACHE_LOAD_IN;
  logic [1:0]  DATA_CACHE_STORE_IN;
  logic [31:0] DATA_CACHE_STORE_DATA_IN;
  logic        WRITE_BACK_MUX_SELECT_IN;
  logic        RD_WRITE_ENABLE_IN;
  logic        STALL_PIPELINE;
  logic        DCACHE_REQ_VALID;
  logic        DCACHE_REQ_READY;
  logic [31:0] DCACHE_ADDR;
  logic        DCACHE_WE;
  logic [3:0]  DCACHE_BYTE_EN;
  logic [31:0] DCACHE_WDATA;
  logic        DCACHE_RVALID;
  logic [31:0] DCACHE_RDATA;
  logic [4:0]  RD_ADDRESS_OUT;
  logic [31:0] WB_DATA_OUT;
  logic        RD_WRITE_ENABLE_OUT;
  logic        MISALIGN_FAULT;
  logic [1:0]  FSM_STATE_DBG;

  int          checks = 0;
  int          errors = 0;
  int          ready_delay = 0;
  int          rvalid_delay = 0;
  logic [31:0] rdata_cfg = '0;
  int          valid_cycles = 0;
  int          mis_seen = 0;
  int          mis_exp = 0;
  logic [WB_W-1:0]  exp_q[$];
  logic [REQ_W-1:0] req_q[$];

  always #5 CLK = ~CLK;

  memory_access_stage dut (
    .CLK(CLK), .RST_N(RST_N),
    .RD_ADDRESS_IN(RD_ADDRESS_IN), .ALU_IN(ALU_IN),
    .DATA_CACHE_LOAD_IN(DATA_CACHE_LOAD_IN), .DATA_CACHE_STORE_IN(DATA_CACHE_STORE_IN),
    .DATA_CACHE_STORE_DATA_IN(DATA_CACHE_STORE_DATA_IN),
    .WRITE_BACK_MUX_SELECT_IN(WRITE_BACK_MUX_SELECT_IN), .RD_WRITE_ENABLE_IN(RD_WRITE_ENABLE_IN),
    .STALL_PIPELINE(STALL_PIPELINE),
    .DCACHE_REQ_VALID(DCACHE_REQ_VALID), .DCACHE_REQ_READY(DCACHE_REQ_READY),
    .DCACHE_ADDR(DCACHE_ADDR), .DCACHE_WE(DCACHE_WE), .DCACHE_BYTE_EN(DCACHE_BYTE_EN),
    .DCACHE_WDATA(DCACHE_WDATA), .DCACHE_RVALID(DCACHE_RVALID), .DCACHE_RDATA(DCACHE_RDATA),
    .RD_ADDRESS_OUT(RD_ADDRESS_OUT), .WB_DATA_OUT(WB_DATA_OUT),
    .RD_WRITE_ENABLE_OUT(RD_WRITE_ENABLE_OUT), .MISALIGN_FAULT(MISALIGN_FAULT),
    .FSM_STATE_DBG(FSM_STATE_DBG)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] ld, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] s;
    s = w >> (a * 8);
    case (ld)
      3'd2:    ref_load = {{16{s[15]}}, s[15:0]};
      3'd3:    ref_load = {16'h0, s[15:0]};
      3'd4:    ref_load = {{24{s[7]}}, s[7:0]};
      3'd5:    ref_load = {24'h0, s[7:0]};
      default: ref_load = w;
    endcase
  endfunction

  task automatic drive_idle();
    RD_ADDRESS_IN = '0; ALU_IN = '0; DATA_CACHE_LOAD_IN = '0; DATA_CACHE_STORE_IN = '0;
    DATA_CACHE_STORE_DATA_IN = '0; WRITE_BACK_MUX_SELECT_IN = 1'b0; RD_WRITE_ENABLE_IN = 1'b0;
  endtask

  task automatic check_zero_outputs(input string where);
    check({where, "_valid"}, 32'(DCACHE_REQ_VALID), 0);
    check({where, "_addr"}, DCACHE_ADDR, 0);
    check({where, "_we"}, 32'(DCACHE_WE), 0);
    check({where, "_be"}, 32'(DCACHE_BYTE_EN), 0);
    check({where, "_wdata"}, DCACHE_WDATA, 0);
    check({where, "_rd_out"}, 32'(RD_ADDRESS_OUT), 0);
    check({where, "_wb_data"}, WB_DATA_OUT, 0);
    check({where, "_rd_we"}, 32'(RD_WRITE_ENABLE_OUT), 0);
    check({where, "_misalign"}, 32'(MISALIGN_FAULT), 0);
    check({where, "_stall"}, 32'(STALL_PIPELINE), 0);
    check({where, "_state"}, 32'(FSM_STATE_DBG), 0);
  endtask

  // Called at negedge+1; drives one EX op, records expectations, holds it until accepted.
  task automatic send_op(input logic [4:0] rd, input logic [31:0] alu, input logic [2:0] ld,
                         input logic [1:0] st, input logic [31:0] sd, input logic wbsel,
                         input logic we);
    logic is_ld, is_st, mis;
    logic [3:0] be;
    logic [31:0] wd;
    int exp_cyc, exp_valid, cyc, v0;
    bit acc, done;
    is_ld = (ld >= 3'd1) && (ld <= 3'd5);
    is_st = !is_ld && (st != 2'd0);
    mis = 1'b0;
    if ((is_ld && ld == 3'd1) || (is_st && st == 2'd1)) mis = (alu[1:0] != 2'd0);
    else if ((is_ld && (ld == 3'd2 || ld == 3'd3)) || (is_st && st == 2'd2)) mis = alu[0];
    RD_ADDRESS_IN = rd; ALU_IN = alu; DATA_CACHE_LOAD_IN = ld; DATA_CACHE_STORE_IN = st;
    DATA_CACHE_STORE_DATA_IN = sd; WRITE_BACK_MUX_SELECT_IN = wbsel; RD_WRITE_ENABLE_IN = we;
    exp_cyc = 1;
    exp_valid = 0;
    if (mis) begin
      mis_exp++;
    end else if (is_ld) begin
      req_q.push_back({alu & ~32'h3, 1'b0, 4'b0000, 32'h0});
      if (we) exp_q.push_back({rd, wbsel ? ref_load(ld, alu[1:0], rdata_cfg) : alu});
      exp_cyc = 3 + ready_delay + rvalid_delay;
      exp_valid = ready_delay + 1;
    end else if (is_st) begin
      case (st)
        2'd1: begin be = 4'hF; wd = sd; end
        2'd2: begin be = alu[1] ? 4'b1100 : 4'b0011; wd = sd[15:0] * 32'h0001_0001; end
        default: begin
          be = {alu[1:0] == 2'd3, alu[1:0] == 2'd2, alu[1:0] == 2'd1, alu[1:0] == 2'd0};
          wd = sd[7:0] * 32'h0101_0101;
        end
      endcase
      req_q.push_back({alu & ~32'h3, 1'b1, be, wd});
      exp_cyc = 2 + ready_delay;
      exp_valid = ready_delay + 1;
    end else if (we) begin
      exp_q.push_back({rd, alu});
    end
    v0 = valid_cycles;
    #1;
    cyc = 0;
    done = 0;
    while (!done) begin
      acc = !STALL_PIPELINE;
      @(negedge CLK);
      #1;
      cyc++;
      if (acc) done = 1;
      else if (cyc > 40) begin
        check("stall_timeout", 32'(STALL_PIPELINE), 0);
        done = 1;
      end
    end
    check("latency", cyc, exp_cyc);
    check("valid_cycles", valid_cycles - v0, exp_valid);
    check("misalign_pulse", 32'(MISALIGN_FAULT), 32'(mis));
    if (mis || is_st) check("no_wb_we", 32'(RD_WRITE_ENABLE_OUT), 0);
    drive_idle();
  endtask

  // Data cache responder: READY after ready_delay VALID cycles, RVALID rvalid_delay cycles
  // after a load handshake. Also checks each VALID cycle against the request queue head.
  initial begin : cache_model
    int req_cnt;
    int rv_cnt;
    bit hs_next;
    bit hs_load;
    logic [REQ_W-1:0] e;
    req_cnt = 0; rv_cnt = -1; hs_next = 0; hs_load = 0;
    DCACHE_REQ_READY = 1'b0; DCACHE_RVALID = 1'b0; DCACHE_RDATA = '0;
    forever begin
      @(negedge CLK);
      DCACHE_RVALID = 1'b0;
      if (hs_next) begin
        hs_next = 0;
        DCACHE_REQ_READY = 1'b0;
        if (hs_load) rv_cnt = rvalid_delay;
      end
      if (!RST_N) begin
        DCACHE_REQ_READY = 1'b0;
        req_cnt = 0;
      end
      if (rv_cnt == 0) begin
        DCACHE_RVALID = 1'b1;
        DCACHE_RDATA = rdata_cfg;
        rv_cnt = -1;
      end else if (rv_cnt > 0) begin
        rv_cnt--;
      end
      if (DCACHE_REQ_VALID) begin
        valid_cycles++;
        if (req_q.size() == 0) begin
          check("req_unexpected", 32'(DCACHE_REQ_VALID), 0);
        end else begin
          e = req_q[0];
          check("req_addr", DCACHE_ADDR, e[68:37]);
          check("req_we", 32'(DCACHE_WE), 32'(e[36]));
          check("req_be", 32'(DCACHE_BYTE_EN), 32'(e[35:32]));
          if (e[36]) check("req_wdata", DCACHE_WDATA, e[31:0]);
          if (!DCACHE_REQ_READY) begin
            if (req_cnt >= ready_delay) begin
              DCACHE_REQ_READY = 1'b1;
              req_cnt = 0;
            end else begin
              req_cnt++;
            end
          end
          if (DCACHE_REQ_READY) begin
            void'(req_q.pop_front());
            hs_next = 1;
            hs_load = !e[36];
          end
        end
      end
    end
  end

  initial begin : wb_monitor
    logic [WB_W-1:0] e;
    forever begin
      @(negedge CLK);
      if (MISALIGN_FAULT) mis_seen++;
      if (RD_WRITE_ENABLE_OUT) begin
        if (exp_q.size() == 0) begin
          check("wb_we_unexpected", 32'(RD_WRITE_ENABLE_OUT), 0);
        end else begin
          e = exp_q.pop_front();
          check("wb_rd", 32'(RD_ADDRESS_OUT), 32'(e[36:32]));
          check("wb_data", WB_DATA_OUT, e[31:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] a;
    RST_N = 1'b0;
    drive_idle();
    repeat (3) @(negedge CLK);
    #1;
    check_zero_outputs("reset");
    RST_N = 1'b1;
    @(negedge CLK);
    #1;

    send_op(5'd5, 32'h1234, 3'd0, 2'd0, 32'h0, 1'b0, 1'b1);
    check("alu_rd_out", 32'(RD_ADDRESS_OUT), 5);
    check("alu_wb_data", WB_DATA_OUT, 32'h1234);
    check("alu_we_out", 32'(RD_WRITE_ENABLE_OUT), 1);

    ready_delay = 0;
    send_op(5'd7, 32'h103, 3'd0, 2'd3, 32'hAB, 1'b0, 1'b1);

    ready_delay = 2; rvalid_delay = 2; rdata_cfg = 32'h0080_0000;
    send_op(5'd3, 32'h102, 3'd4, 2'd0, 32'h0, 1'b1, 1'b1);
    check("lb_wb_data", WB_DATA_OUT, 32'hFFFF_FF80);
    check("lb_we_out", 32'(RD_WRITE_ENABLE_OUT), 1);

    ready_delay = 0; rvalid_delay = 0; rdata_cfg = 32'h8001_FFFF;
    send_op(5'd4, 32'h202, 3'd3, 2'd0, 32'h0, 1'b1, 1'b1);
    check("lhu_wb_data", WB_DATA_OUT, 32'h0000_8001);

    send_op(5'd6, 32'h201, 3'd1, 2'd0, 32'h0, 1'b1, 1'b1);
    send_op(5'd9, 32'h502, 3'd0, 2'd2, 32'h1234_5678, 1'b0, 1'b1);
    rdata_cfg = 32'h0000_8765;
    send_op(5'd10, 32'h600, 3'd2, 2'd0, 32'h0, 1'b1, 1'b1);
    check("lh_wb_data", WB_DATA_OUT, 32'hFFFF_8765);
    rdata_cfg = 32'h0000_9A00;
    send_op(5'd11, 32'h701, 3'd5, 2'd0, 32'h0, 1'b1, 1'b1);
    rdata_cfg = 32'hDEAD_0000;
    send_op(5'd12, 32'h800, 3'd1, 2'd0, 32'h0, 1'b0, 1'b1);
    check("lw_alu_select", WB_DATA_OUT, 32'h800);
    send_op(5'd13, 32'h55, 3'd6, 2'd0, 32'h0, 1'b1, 1'b1);
    rdata_cfg = 32'h1122_3344;
    send_op(5'd14, 32'h903, 3'd5, 2'd1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check("load_wins_data", WB_DATA_OUT, 32'h11);
    send_op(5'd15, 32'hA01, 3'd0, 2'd2, 32'h1, 1'b0, 1'b1);

    // Reset while the load waits for its response; the late RVALID must be dropped.
    ready_delay = 0; rvalid_delay = 5; rdata_cfg = 32'hBAD0_BAD0;
    RD_ADDRESS_IN = 5'd9; ALU_IN = 32'h300; DATA_CACHE_LOAD_IN = 3'd1;
    WRITE_BACK_MUX_SELECT_IN = 1'b1; RD_WRITE_ENABLE_IN = 1'b1;
    req_q.push_back({32'h300, 1'b0, 4'b0000, 32'h0});
    @(negedge CLK);
    #1;
    check("rst_test_in_req", 32'(FSM_STATE_DBG), 1);
    @(negedge CLK);
    #1;
    check("rst_test_in_wait", 32'(FSM_STATE_DBG), 2);
    RST_N = 1'b0;
    drive_idle();
    #1;
    check_zero_outputs("mid_wait_reset");
    repeat (2) @(negedge CLK);
    #1;
    RST_N = 1'b1;
    repeat (6) @(negedge CLK);
    #1;
    check("late_rvalid_state", 32'(FSM_STATE_DBG), 0);
    check("late_rvalid_wb", WB_DATA_OUT, 0);
    check("late_rvalid_stall", 32'(STALL_PIPELINE), 0);
    rvalid_delay = 0;
    send_op(5'd2, 32'hCAFE, 3'd0, 2'd0, 32'h0, 1'b0, 1'b1);
    check("post_reset_alu", WB_DATA_OUT, 32'hCAFE);

    rdata_cfg = 32'hCAFE_F00D;
    send_op(5'd20, 32'h400, 3'd0, 2'd1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    send_op(5'd21, 32'h404, 3'd1, 2'd0, 32'h0, 1'b1, 1'b1);
    check("b2b_lw_data", WB_DATA_OUT, 32'hCAFE_F00D);

    for (int i = 0; i < 12; i++) begin
      ready_delay = $urandom_range(0, 2);
      rvalid_delay = $urandom_range(0, 2);
      rdata_cfg = $urandom;
      a = $urandom & 32'h0000_FFFC;
      case ($urandom_range(0, 3))
        0: send_op(5'($urandom_range(1, 31)), $urandom, 3'd0, 2'd0, 32'h0, 1'b0, 1'b1);
        1: send_op(5'($urandom_range(1, 31)), a, 3'd1, 2'd0, 32'h0, 1'b1, 1'b1);
        2: send_op(5'($urandom_range(1, 31)), a, 3'd0, 2'd1, $urandom, 1'b0, 1'b1);
        default: send_op(5'($urandom_range(1, 31)), a | 32'($urandom_range(0, 3)), 3'd4, 2'd0,
                         32'h0, 1'b1, 1'b1);
      endcase
    end

    repeat (5) @(negedge CLK);
    #1;
    check("wb_queue_drained", exp_q.size(), 0);
    check("req_queue_drained", req_q.size(), 0);
    check("misalign_count", mis_seen, mis_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
